// File: rtl/ahb_bram_preload_128_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the BRAM boot preload engine.
package ahb_bram_preload_128_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [2:0] HSIZE_128 = 3'b100;

    localparam int LINE_BYTES = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } state_e;

endpackage

// File: rtl/ahb_bram_preload_128_bram_line_packer.sv
// Packs a byte stream little-endian into 128-bit lines; line_full marks the 16th accept.
module ahb_bram_preload_128_bram_line_packer
    import ahb_bram_preload_128_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         enable,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         line_full,
    output logic [127:0] line_buf
);

    logic [3:0]   byte_cnt_q, byte_cnt_d;
    logic [127:0] line_buf_q, line_buf_d;
    logic         accept;

    always_comb begin
        accept     = enable & in_valid;
        line_full  = accept && (byte_cnt_q == 4'(LINE_BYTES - 1));
        byte_cnt_d = byte_cnt_q;
        line_buf_d = line_buf_q;
        if (clear) begin
            byte_cnt_d = '0;
        end else if (accept) begin
            // Byte n lands in lane n; the 4-bit counter wraps to 0 after the 16th byte.
            line_buf_d[{byte_cnt_q, 3'b000} +: 8] = in_data;
            byte_cnt_d = byte_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            line_buf_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            line_buf_q <= line_buf_d;
        end
    end

    assign line_buf = line_buf_q;

endmodule

// File: rtl/ahb_bram_preload_128.sv
// AHB-Lite boot preload master: collects 16 stream bytes per line and writes each line
// to the 128-bit BRAM as a single NONSEQ transfer, reporting done/error to the boot controller.
module ahb_bram_preload_128
    import ahb_bram_preload_128_pkg::*;
#(
    parameter int ADDRESSWIDTH = 18,
    parameter int NUMWORDS     = 16384,
    parameter int BASEWORD     = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    start,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDRESSWIDTH-1:0] HADDR,
    output logic [1:0]              HTRANS,
    output logic [2:0]              HSIZE,
    output logic                    HWRITE,
    output logic [127:0]            HWDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    localparam int LW = ADDRESSWIDTH - 4;
    localparam int CW = ADDRESSWIDTH - 3;
    localparam logic [LW-1:0] BASE_L   = LW'(BASEWORD);
    localparam logic [CW-1:0] LAST_CNT = CW'(NUMWORDS - 1);

    state_e                  state_q, state_d;
    logic [1:0]              htrans_q, htrans_d;
    logic                    hwrite_q, hwrite_d;
    logic [ADDRESSWIDTH-1:0] haddr_q, haddr_d;
    logic [127:0]            hwdata_q, hwdata_d;
    logic                    in_ready_q, in_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [CW-1:0]           line_cnt_q, line_cnt_d;

    logic                    start_acc;
    logic                    line_full;
    logic [127:0]            line_buf;

    ahb_bram_preload_128_bram_line_packer u_packer (
        .clk       (HCLK),
        .rst_n     (HRESETn),
        .clear     (start_acc),
        .enable    (in_ready_q),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .line_full (line_full),
        .line_buf  (line_buf)
    );

    always_comb begin
        start_acc  = start && (state_q == ST_IDLE || state_q == ST_DONE);
        state_d    = state_q;
        htrans_d   = htrans_q;
        hwrite_d   = hwrite_q;
        haddr_d    = haddr_q;
        hwdata_d   = hwdata_q;
        in_ready_d = in_ready_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        line_cnt_d = line_cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_COLLECT;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    line_cnt_d = '0;
                    in_ready_d = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (line_full) begin
                    state_d    = ST_ADDR;
                    in_ready_d = 1'b0;
                    htrans_d   = HTRANS_NONSEQ;
                    hwrite_d   = 1'b1;
                    haddr_d    = {BASE_L + line_cnt_q[LW-1:0], 4'b0000};
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    state_d  = ST_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwrite_d = 1'b0;
                    hwdata_d = line_buf;
                end
            end
            ST_DATA: begin
                // Either cycle of the two-cycle ERROR response aborts the load.
                if (HRESP == HRESP_ERROR) begin
                    state_d = ST_DONE;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (HREADY) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                    if (line_cnt_q == LAST_CNT) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = ST_COLLECT;
                        in_ready_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            htrans_q   <= HTRANS_IDLE;
            hwrite_q   <= 1'b0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            line_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            htrans_q   <= htrans_d;
            hwrite_q   <= hwrite_d;
            haddr_q    <= haddr_d;
            hwdata_q   <= hwdata_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign in_ready = in_ready_q;
    assign HADDR    = haddr_q;
    assign HTRANS   = htrans_q;
    assign HSIZE    = HSIZE_128;
    assign HWRITE   = hwrite_q;
    assign HWDATA   = hwdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ahb_bram_preload_128.sv
// Directed bench: two DUTs (BASEWORD 0 and 0x3FFE, NUMWORDS 2) share one stimulus stream.
module tb_ahb_bram_preload_128;

    logic         HCLK = 1'b0;
    logic         HRESETn = 1'b0;
    logic         start = 1'b0;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         HREADY = 1'b1;
    logic         HRESP = 1'b0;

    logic         in_ready0, in_ready1;
    logic [17:0]  haddr0, haddr1;
    logic [1:0]   htrans0, htrans1;
    logic [2:0]   hsize0, hsize1;
    logic         hwrite0, hwrite1;
    logic [127:0] hwdata0, hwdata1;
    logic         busy0, busy1, done0, done1, error0, error1;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_bram_preload_128 #(.ADDRESSWIDTH(18), .NUMWORDS(2), .BASEWORD(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready0), .HADDR(haddr0), .HTRANS(htrans0),
        .HSIZE(hsize0), .HWRITE(hwrite0), .HWDATA(hwdata0), .HREADY(HREADY),
        .HRESP(HRESP), .busy(busy0), .done(done0), .error(error0)
    );

    ahb_bram_preload_128 #(.ADDRESSWIDTH(18), .NUMWORDS(2), .BASEWORD(16'h3FFE)) u_dut1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready1), .HADDR(haddr1), .HTRANS(htrans1),
        .HSIZE(hsize1), .HWRITE(hwrite1), .HWDATA(hwdata1), .HREADY(HREADY),
        .HRESP(HRESP), .busy(busy1), .done(done1), .error(error1)
    );

    typedef struct {
        logic [7:0]   base;       // first stream byte of the load
        int           aw;         // HREADY-low cycles in the address phase
        int           dw;         // HREADY-low cycles in the data phase
        bit           gap;        // in_valid toggles every other cycle
        bit           mid_start;  // pulse start while busy
        logic [127:0] exp_l0;
        logic [127:0] exp_l1;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic run_load(input vec_t v);
        int n, guard;
        bit tog;
        logic acc;
        logic [127:0] exp;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", busy0, 1);
        chk("start_done_clr", done0, 0);
        for (int l = 0; l < 2; l++) begin
            n = 0; guard = 0; tog = 1'b1;
            while (n < 16 && guard < 100) begin
                in_valid = v.gap ? tog : 1'b1;
                in_data  = v.base + 8'(16 * l + n);
                start    = v.mid_start && (l == 0) && (n == 5);
                acc      = in_valid & in_ready0;
                tick();
                if (acc) n++;
                tog = !tog;
                guard++;
            end
            in_valid = 1'b0;
            start    = 1'b0;
            exp = (l == 0) ? v.exp_l0 : v.exp_l1;
            chk("collect_16", n, 16);
            chk("addr_htrans", htrans0, 2);
            chk("addr_hwrite", hwrite0, 1);
            chk("addr_hsize", hsize0, 3'b100);
            chk("addr_haddr0", haddr0, 18'(l * 16));
            chk("addr_haddr1", haddr1, 18'h3FFE0 + 18'(l * 16));
            chk("addr_in_ready", in_ready0, 0);
            HREADY = 1'b0;
            for (int w = 0; w < v.aw; w++) begin
                tick();
                chk("addr_hold_htrans", htrans0, 2);
                chk("addr_hold_haddr", haddr0, 18'(l * 16));
            end
            HREADY = 1'b1;
            tick();
            chk("data_htrans", htrans0, 0);
            chk("data_hwrite", hwrite0, 0);
            chk("data_hwdata0", hwdata0, exp);
            chk("data_hwdata1", hwdata1, exp);
            chk("data_in_ready", in_ready0, 0);
            HREADY = 1'b0;
            for (int w = 0; w < v.dw; w++) begin
                tick();
                chk("data_hold_hwdata", hwdata0, exp);
                chk("data_hold_htrans", htrans0, 0);
            end
            HREADY = 1'b1;
            tick();
            if (l == 0) chk("next_collect", in_ready0, 1);
        end
        chk("end_done0", done0, 1);
        chk("end_busy0", busy0, 0);
        chk("end_error0", error0, 0);
        chk("end_done1", done1, 1);
        chk("end_busy1", busy1, 0);
    endtask

    initial begin
        int n;
        logic saw_nonseq, saw_ready;

        vecs[0] = '{8'h00, 0, 0, 1'b0, 1'b0,
                    128'h0F0E0D0C0B0A09080706050403020100,
                    128'h1F1E1D1C1B1A19181716151413121110};
        vecs[1] = '{8'h00, 3, 2, 1'b0, 1'b0,
                    128'h0F0E0D0C0B0A09080706050403020100,
                    128'h1F1E1D1C1B1A19181716151413121110};
        vecs[2] = '{8'h40, 0, 0, 1'b1, 1'b0,
                    128'h4F4E4D4C4B4A49484746454443424140,
                    128'h5F5E5D5C5B5A59585756555453525150};
        vecs[3] = '{8'hA0, 1, 1, 1'b1, 1'b1,
                    128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0,
                    128'hBFBEBDBCBBBAB9B8B7B6B5B4B3B2B1B0};

        // Reset state
        tick();
        tick();
        chk("rst_htrans", htrans0, 0);
        chk("rst_haddr", haddr0, 0);
        chk("rst_hwdata", hwdata0, 0);
        chk("rst_hwrite", hwrite0, 0);
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_flags", {busy0, done0, error0}, 0);
        HRESETn = 1'b1;
        tick();
        chk("idle_busy", busy0, 0);

        for (int i = 0; i < 4; i++) run_load(vecs[i]);

        // ERROR response during the first data phase
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        in_valid = 1'b1;
        while (n < 16 && in_ready0) begin
            in_data = 8'(n);
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk("err_collect_16", n, 16);
        chk("err_addr_htrans", htrans0, 2);
        tick();
        chk("err_data_htrans", htrans0, 0);
        HREADY = 1'b0;
        HRESP  = 1'b1;
        tick();
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("err_error", error0, 1);
        chk("err_done", done0, 0);
        chk("err_busy", busy0, 0);
        chk("err_error1", error1, 1);
        saw_nonseq = 1'b0;
        saw_ready  = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (htrans0 != 2'b00) saw_nonseq = 1'b1;
            if (in_ready0) saw_ready = 1'b1;
        end
        in_valid = 1'b0;
        chk("err_no_second_nonseq", saw_nonseq, 0);
        chk("err_no_ready", saw_ready, 0);

        // Asynchronous reset after 7 bytes
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        for (int b = 0; b < 7; b++) begin
            in_data = 8'hE0 + 8'(b);
            tick();
        end
        in_valid = 1'b0;
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_htrans", htrans0, 0);
        chk("arst_in_ready", in_ready0, 0);
        chk("arst_busy", busy0, 0);
        tick();
        HRESETn = 1'b1;
        tick();
        run_load(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
